bram_word_adapter: RTL and testbench
====================================

// Module: bram_word_adapter
// PURPOSE
//   Bridges the CPU-side 32-bit load/store request port to the 8-bit BRAM
//   (1-cycle registered read, ren/wen strobes). Sequences 1/2/4 byte accesses
//   little-endian, assembles read data and returns a one-cycle response pulse.
//   Sits between the core's data bus decode and the BRAM instance.
// PARAMETERS
//   ADDR_WIDTH  10  byte address width; must match the BRAM it drives
// PORTS
//   clk          in   1           system clock, all logic on posedge
//   rst_n        in   1           synchronous reset, active low
//   req_valid    in   1           request present
//   req_ready    out  1           adapter idle, request accepted when valid&ready
//   req_write    in   1           1 = store, 0 = load
//   req_size     in   2           0 byte, 1 half, 2 word, 3 treated as word
//   req_addr     in   ADDR_WIDTH  byte address of lowest byte
//   req_wdata    in   32          store data, byte k at [8k+7:8k]
//   rsp_valid    out  1           one-cycle completion pulse (loads and stores)
//   rsp_rdata    out  32          load data, zero-extended, valid with rsp_valid
//   rsp_err      out  1           misalignment flag, valid with rsp_valid
//   bram_addr    out  ADDR_WIDTH  to BRAM addr
//   bram_wdata   out  8           to BRAM data_in
//   bram_rdata   in   8           from BRAM data_out
//   bram_wen     out  1           to BRAM wen
//   bram_ren     out  1           to BRAM ren
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): state IDLE; rsp_valid, rsp_rdata, rsp_err,
//     bram_wen, bram_ren, bram_addr, bram_wdata all 0; req_ready forced 0
//     while rst_n=0. Reset mid-operation aborts: no rsp, strobes low next edge.
//   - All bram_* and rsp_* outputs registered. req_ready = (state==IDLE)&rst_n.
//   - n = 1/2/4 bytes per size. Byte k address = req_addr+k mod 2^ADDR_WIDTH
//     (wraps at top of memory; misaligned allowed unless checked, see below).
//   - FSM: IDLE -> (accept) ISSUE -> [loads] DRAIN -> DONE -> IDLE.
//     IDLE : latch addr/size/write/wdata on accept, count k=0.
//     ISSUE: one byte per cycle, k=0..n-1; ren (load) or wen+wdata (store).
//     DRAIN: load only; capture final byte one cycle after last ren.
//     DONE : rsp_valid=1 one cycle; state returns to IDLE (req_ready=1 next).
//   - Timing, accept at cycle T: strobes cycles T+1..T+n. Load byte k read
//     from bram_rdata in cycle T+2+k into rsp_rdata[8k+7:8k]; rsp_valid in
//     cycle T+n+2. Store: rsp_valid in cycle T+n+1.
//   - Load: rsp_rdata cleared at accept; bytes >= n stay 0. Held until next
//     load accept. Stores leave rsp_rdata unchanged.
//   - ren and wen never both high. bram_ren/wen low in IDLE/DRAIN/DONE.
//   - req_valid while busy ignored (req_ready=0); requester must hold.
// CONFIGURATION
//   BRAM_ADAPTER_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with
//     addr[1:0]!=0 is not performed; no strobes; rsp_valid at T+1 with
//     rsp_err=1, rsp_rdata=0.
//   Undefined: no check, misaligned bytes accessed with wrap; rsp_err tied 0.
// TESTING
//   1 Store word 0xA1B2C3D4 @0x010 -> wen T+1..T+4, addr 0x010..0x013,
//     wdata D4,C3,B2,A1; rsp_valid T+5, rsp_err=0.
//   2 Load word @0x010 after (1) -> ren T+1..T+4, rsp_valid T+6,
//     rsp_rdata=0xA1B2C3D4.
//   3 Load byte @0x012 -> rsp_rdata=0x000000B2 at T+3; half @0x012 ->
//     0x0000A1B2 at T+4.
//   4 Word store 0x11223344 @0x3FE (ADDR_WIDTH=10, no check) -> addr 3FE,3FF,
//     000,001; reload returns 0x11223344. With BRAM_ADAPTER_ALIGN_CHECK_EN:
//     no wen, rsp_err=1 at T+1.
//   5 rst_n low at T+2 of a word load -> strobes 0 next edge, no rsp_valid,
//     req_ready=1 first cycle after release; next load completes normally.
//   6 Back-to-back: req_valid held with new load during busy -> accepted in
//     cycle after rsp_valid pulse; ren never overlaps wen.

Source files
------------

// File: rtl/bram_word_adapter.sv
// 32-bit load/store port to 8-bit registered-read BRAM bridge, little-endian byte sequencing.
// Optional BRAM_ADAPTER_ALIGN_CHECK_EN rejects misaligned half/word accesses with rsp_err.
module bram_word_adapter #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [7:0]            bram_wdata,
    input  logic [7:0]            bram_rdata,
    output logic                  bram_wen,
    output logic                  bram_ren
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr_base;
    logic [31:0]           r_wdata;
    logic [2:0]            r_n;
    logic [2:0]            r_k;
    logic [1:0]            r_strobe_idx;
    logic                  r_rd_pend;
    logic [1:0]            r_rd_idx;
    logic [ADDR_WIDTH-1:0] r_bram_addr;
    logic [7:0]            r_bram_wdata;
    logic                  r_bram_wen;
    logic                  r_bram_ren;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_misalign;
    logic [2:0]            w_req_n;
    logic                  w_drive;
    logic                  w_drive_wr;
    logic [ADDR_WIDTH-1:0] w_drive_addr;
    logic [7:0]            w_drive_wdata;
    logic [1:0]            w_drive_idx;
    logic                  w_rsp_fire;
    logic                  w_rsp_err;

    assign req_ready  = (r_state == S_IDLE) & rst_n;
    assign w_accept   = req_valid & req_ready;

    assign bram_addr  = r_bram_addr;
    assign bram_wdata = r_bram_wdata;
    assign bram_wen   = r_bram_wen;
    assign bram_ren   = r_bram_ren;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;

    always_comb begin
        case (req_size)
            2'd0:    w_req_n = 3'd1;
            2'd1:    w_req_n = 3'd2;
            default: w_req_n = 3'd4;
        endcase
    end

`ifdef BRAM_ADAPTER_ALIGN_CHECK_EN
    assign w_misalign = ((req_size == 2'd1) & req_addr[0])
                      | (req_size[1] & (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Byte 0 is launched on the accept edge so strobes land in cycles T+1..T+n.
    always_comb begin
        w_state_next  = r_state;
        w_drive       = 1'b0;
        w_drive_wr    = 1'b0;
        w_drive_addr  = r_bram_addr;
        w_drive_wdata = r_bram_wdata;
        w_drive_idx   = 2'd0;
        w_rsp_fire    = 1'b0;
        w_rsp_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_state_next = S_DONE;
                        w_rsp_fire   = 1'b1;
                        w_rsp_err    = 1'b1;
                    end else begin
                        w_state_next  = S_ISSUE;
                        w_drive       = 1'b1;
                        w_drive_wr    = req_write;
                        w_drive_addr  = req_addr;
                        w_drive_wdata = req_wdata[7:0];
                        w_drive_idx   = 2'd0;
                    end
                end
            end
            S_ISSUE: begin
                if (r_k < r_n) begin
                    w_drive       = 1'b1;
                    w_drive_wr    = r_write;
                    w_drive_addr  = r_addr_base + ADDR_WIDTH'(r_k);
                    w_drive_wdata = r_wdata[{r_k[1:0], 3'b000} +: 8];
                    w_drive_idx   = r_k[1:0];
                end else if (r_write) begin
                    w_state_next = S_DONE;
                    w_rsp_fire   = 1'b1;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last read byte is on bram_rdata now and is captured on this edge.
                w_state_next = S_DONE;
                w_rsp_fire   = 1'b1;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write      <= 1'b0;
            r_addr_base  <= '0;
            r_wdata      <= '0;
            r_n          <= 3'd0;
            r_k          <= 3'd0;
            r_strobe_idx <= 2'd0;
            r_rd_pend    <= 1'b0;
            r_rd_idx     <= 2'd0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
            r_bram_wen   <= 1'b0;
            r_bram_ren   <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_bram_wen <= w_drive & w_drive_wr;
            r_bram_ren <= w_drive & ~w_drive_wr;
            if (w_drive) begin
                r_bram_addr  <= w_drive_addr;
                r_bram_wdata <= w_drive_wdata;
                r_strobe_idx <= w_drive_idx;
            end

            // BRAM read latency is one cycle: the lane follows its ren by one clock.
            r_rd_pend <= r_bram_ren;
            r_rd_idx  <= r_strobe_idx;

            if (w_accept) begin
                r_addr_base <= req_addr;
                r_write     <= req_write;
                r_wdata     <= req_wdata;
                r_n         <= w_req_n;
                r_k         <= 3'd1;
            end else if (w_drive) begin
                r_k <= r_k + 3'd1;
            end

            if (w_accept & (~req_write | w_misalign)) begin
                r_rsp_rdata <= '0;
            end else if (r_rd_pend) begin
                r_rsp_rdata[{r_rd_idx, 3'b000} +: 8] <= bram_rdata;
            end

            r_rsp_valid <= w_rsp_fire;
            r_rsp_err   <= w_rsp_err;
        end
    end

endmodule

// File: tb/tb_bram_word_adapter.sv
// Scoreboard bench for bram_word_adapter: BRAM model, byte-array reference, decoupled monitor.
module tb_bram_word_adapter;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_wdata;
    logic [7:0]    bram_rdata = 8'h0;
    logic          bram_wen;
    logic          bram_ren;

    logic          tb_init = 1'b1;
    logic          done = 1'b0;
    int            cyc = 0;

    bram_word_adapter #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .bram_wen   (bram_wen),
        .bram_ren   (bram_ren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with one-cycle registered read
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'(i * 37 + 5);
        end else if (bram_wen) begin
            mem[bram_addr] <= bram_wdata;
        end
        if (bram_ren) bram_rdata <= mem[bram_addr];
    end

    typedef struct {
        int            cyc;
        logic          wr;
        logic [AW-1:0] addr;
        logic [7:0]    wd;
    } strobe_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    strobe_t     sq[$];
    rsp_t        rq[$];
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    logic [31:0] last_rd = 32'h0;
    int          errors = 0;
    int          checks = 0;
    int          last_rsp_cyc = -10;
    int          hold = 0;
    logic        prev_rst_low = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_rst_n = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        strobe_t     se;
        rsp_t        re;
        bit          exp_strobe;
        bit          exp_rsp;
        bit          mis;
        int          n;
        logic [31:0] val;
        logic [AW-1:0] a;
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (tb_init) begin
                for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'(i * 37 + 5);
            end

            if (prev_rst_low) begin
                check(req_ready == rst_n, "rst_req_ready", 32'(req_ready), 32'(rst_n));
                check(!bram_ren && !bram_wen, "rst_strobes", {30'h0, bram_ren, bram_wen}, 32'h0);
                check(bram_addr == '0 && bram_wdata == 8'h0, "rst_bram_bus",
                      32'({bram_addr, bram_wdata}), 32'h0);
                check(!rsp_valid && !rsp_err && rsp_rdata == 32'h0, "rst_rsp", rsp_rdata, 32'h0);
            end

            while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
            while (rq.size() > 0 && rq[0].cyc < cyc) void'(rq.pop_front());

            exp_strobe = (sq.size() > 0 && sq[0].cyc == cyc);
            if (bram_ren || bram_wen || exp_strobe) begin
                check((bram_ren | bram_wen) == exp_strobe, "strobe_timing",
                      32'(bram_ren | bram_wen), 32'(exp_strobe));
                check(!(bram_ren && bram_wen), "ren_wen_overlap", {30'h0, bram_ren, bram_wen}, 32'h0);
            end
            if (exp_strobe) begin
                se = sq.pop_front();
                check(bram_wen == se.wr && bram_ren == !se.wr, "strobe_kind", 32'(bram_wen), 32'(se.wr));
                check(bram_addr == se.addr, "strobe_addr", 32'(bram_addr), 32'(se.addr));
                if (se.wr) check(bram_wdata == se.wd, "strobe_wdata", 32'(bram_wdata), 32'(se.wd));
            end

            exp_rsp = (rq.size() > 0 && rq[0].cyc == cyc);
            if (rsp_valid || exp_rsp) begin
                check(rsp_valid == exp_rsp, "rsp_timing", 32'(rsp_valid), 32'(exp_rsp));
            end
            if (exp_rsp) begin
                re = rq.pop_front();
                $display("rsp cycle=%0d rdata=0x%08h err=%0d", cyc, rsp_rdata, rsp_err);
                check(rsp_rdata == re.rdata, "rsp_rdata", rsp_rdata, re.rdata);
                check(rsp_err == re.err, "rsp_err", 32'(rsp_err), 32'(re.err));
            end
            if (rsp_valid) last_rsp_cyc = cyc;

            if (!rst_n) begin
                sq.delete();
                rq.delete();
                last_rd = 32'h0;
            end

            if (req_valid && req_ready) begin
                if (prev_valid && !prev_ready && prev_rst_n)
                    check(last_rsp_cyc == cyc - 1, "b2b_accept", 32'(cyc), 32'(last_rsp_cyc + 1));
                n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                mis = 1'b0;
`ifdef BRAM_ADAPTER_ALIGN_CHECK_EN
                mis = (n == 2 && req_addr[0]) || (n == 4 && req_addr[1:0] != 2'b00);
`endif
                if (mis) begin
                    rq.push_back('{cyc + 1, 32'h0, 1'b1});
                    last_rd = 32'h0;
                end else begin
                    val = 32'h0;
                    for (int k = 0; k < n; k++) begin
                        a = req_addr + AW'(k);
                        if (req_write) begin
                            b = req_wdata[8*k +: 8];
                            ref_mem[a] = b;
                            sq.push_back('{cyc + 1 + k, 1'b1, a, b});
                        end else begin
                            val[8*k +: 8] = ref_mem[a];
                            sq.push_back('{cyc + 1 + k, 1'b0, a, 8'h0});
                        end
                    end
                    if (req_write) begin
                        rq.push_back('{cyc + n + 1, last_rd, 1'b0});
                    end else begin
                        rq.push_back('{cyc + n + 2, val, 1'b0});
                        last_rd = val;
                    end
                end
            end

            if (req_valid && !req_ready) hold++;
            else hold = 0;
            if (hold == 100) check(req_ready == 1'b1, "accept_timeout", 32'(req_ready), 32'h1);

            prev_rst_low = !rst_n;
            prev_valid   = req_valid;
            prev_ready   = req_ready;
            prev_rst_n   = rst_n;

            if (done) begin
                check(sq.size() == 0, "strobe_queue_drained", 32'(sq.size()), 32'h0);
                check(rq.size() == 0, "rsp_queue_drained", 32'(rq.size()), 32'h0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic req(input bit wr, input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [AW-1:0] a;
        rst_n   = 1'b0;
        tb_init = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        tb_init = 1'b0;
        idle(2);

        req(1'b1, 2'd2, 10'h010, 32'hA1B2C3D4);
        idle(2);
        req(1'b0, 2'd2, 10'h010, 32'h0);
        req(1'b0, 2'd0, 10'h012, 32'h0);
        req(1'b0, 2'd1, 10'h012, 32'h0);
        idle(1);
        req(1'b1, 2'd2, 10'h3FE, 32'h11223344);
        req(1'b0, 2'd2, 10'h3FE, 32'h0);
        idle(3);

        // reset during the third cycle of a word load
        req(1'b0, 2'd2, 10'h010, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req(1'b0, 2'd2, 10'h010, 32'h0);

        for (int t = 0; t < 160; t++) begin
            if ($urandom_range(0, 3) == 0) a = AW'(10'h3FC + 10'($urandom_range(0, 3)));
            else a = AW'($urandom_range(0, 31));
            req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(20);
        done = 1'b1;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
